// File: rtl/ip2_dnn_capture_pkg.sv
// Shared IP2 test-mux types and constants used by the DNN-output capture state machine.
// Period lengths of zero are treated as one by the helper below.
package cms_pix28_package;

   typedef enum logic [2:0] {
      IDLE_IP2_DC       = 3'd0,
      DELAY_TEST_IP2_DC = 3'd1,
      RESET_NOT_IP2_DC  = 3'd2,
      ACQUIRE_IP2_DC    = 3'd3,
      DONE_IP2_DC       = 3'd4
   } state_t_sm_ip2_dnn_capture;

   localparam logic CAPTURE_MODE_FIRST = 1'b0;
   localparam logic CAPTURE_MODE_LAST  = 1'b1;

   function automatic logic [3:0] periods_min1(input logic [3:0] periods);
      return (periods == 4'd0) ? 4'd1 : periods;
   endfunction

endpackage

// File: rtl/ip2_capture_shreg.sv
// Single-channel capture shift register: newest sample enters at the LSB.
// Synchronous clear has priority over shifting.
module ip2_capture_shreg
   import cms_pix28_package::*;
#(
   parameter int DEPTH = 48
) (
   input  logic             clk,
   input  logic             reset_not,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             din,
   output logic [DEPTH-1:0] dout
);

   logic [DEPTH-1:0] shreg_r;

   // Capture register: clear on test start, otherwise shift when enabled
   always_ff @(posedge clk or negedge reset_not) begin
      if (!reset_not) begin
         shreg_r <= '0;
      end else if (clr) begin
         shreg_r <= '0;
      end else if (shift_en) begin
         shreg_r <= {shreg_r[DEPTH-2:0], din};
      end else begin
         shreg_r <= shreg_r;
      end
   end

   assign dout = shreg_r;

endmodule

// File: rtl/ip2_dnn_capture.sv
// IP2 DNN-output capture state machine: sequences DUT reset and trigger pulses
// phase-locked to clk_counter and records N_CH DNN output bits per clock.
module ip2_dnn_capture
   import cms_pix28_package::*;
#(
   parameter int N_CH  = 2,
   parameter int DEPTH = 48,
   parameter int CNT_W = 6
) (
   input  logic                      clk,
   input  logic                      reset_not,
   input  logic                      enable,
   input  logic [CNT_W-1:0]          clk_counter,
   input  logic [CNT_W-1:0]          test_delay,
   input  logic [CNT_W-1:0]          test_trig_out_phase,
   input  logic                      test_mask_reset_not,
   input  logic                      test_start_re,
   input  logic [3:0]                acq_periods,
   input  logic [3:0]                trig_periods,
   input  logic                      capture_mode,
   input  logic [N_CH-1:0]           dnn_in,
   output state_t_sm_ip2_dnn_capture state,
   output logic                      o_reset_not,
   output logic                      o_vin_test_trig_out,
   output logic                      o_status_done,
   output logic                      o_status_overflow,
   output logic [7:0]                o_sample_cnt,
   output logic [N_CH*DEPTH-1:0]     o_dnn_capture
);

   localparam logic [7:0] DEPTH_CNT = 8'(DEPTH);

   state_t_sm_ip2_dnn_capture state_r, state_nxt_s;
   logic [3:0] period_r, period_nxt_s;
   logic [3:0] acq_len_r, trig_req_s, trig_len_s;
   logic       mode_r;
   logic       reset_not_r, reset_not_nxt_s;
   logic       trig_r, trig_nxt_s;
   logic       done_r, overflow_r;
   logic [7:0] sample_cnt_r;
   logic       match_s, trig_phase_s, start_s, active_s, enter_done_s, shift_en_s;

   assign match_s      = (clk_counter == test_delay);
   assign trig_phase_s = (clk_counter == test_trig_out_phase);
   assign start_s      = enable && (state_r == IDLE_IP2_DC) && test_start_re;
   assign active_s     = enable && ((state_r == DELAY_TEST_IP2_DC) ||
                                    (state_r == RESET_NOT_IP2_DC)  ||
                                    (state_r == ACQUIRE_IP2_DC));
   assign enter_done_s = enable && (state_r == ACQUIRE_IP2_DC) && (state_nxt_s == DONE_IP2_DC);
   assign trig_req_s   = periods_min1(trig_periods);
   assign trig_len_s   = (trig_req_s > acq_len_r) ? acq_len_r : trig_req_s;
   // First-mode capture freezes once the register is full
   assign shift_en_s   = active_s && ((mode_r == CAPTURE_MODE_LAST) || (sample_cnt_r < DEPTH_CNT));

   // Next-state, period counter, DUT reset and trigger decode
   always_comb begin
      state_nxt_s     = state_r;
      period_nxt_s    = period_r;
      reset_not_nxt_s = 1'b1;
      trig_nxt_s      = trig_r;
      if (!enable) begin
         state_nxt_s = IDLE_IP2_DC;
         trig_nxt_s  = 1'b0;
      end else begin
         case (state_r)
            IDLE_IP2_DC: begin
               if (test_start_re) begin
                  state_nxt_s  = DELAY_TEST_IP2_DC;
                  period_nxt_s = 4'd0;
               end else begin
                  state_nxt_s = IDLE_IP2_DC;
               end
            end
            DELAY_TEST_IP2_DC: begin
               if (match_s) begin
                  state_nxt_s     = RESET_NOT_IP2_DC;
                  reset_not_nxt_s = test_mask_reset_not;
               end else begin
                  state_nxt_s = DELAY_TEST_IP2_DC;
               end
            end
            RESET_NOT_IP2_DC: begin
               if (match_s) begin
                  state_nxt_s     = ACQUIRE_IP2_DC;
                  reset_not_nxt_s = 1'b1;
               end else begin
                  reset_not_nxt_s = reset_not_r;
               end
            end
            ACQUIRE_IP2_DC: begin
               if (trig_phase_s && (period_r == 4'd0)) begin
                  trig_nxt_s = 1'b1;
               end else if (trig_phase_s && (period_r == trig_len_s)) begin
                  trig_nxt_s = 1'b0;
               end else begin
                  trig_nxt_s = trig_r;
               end
               // The final period boundary ends acquisition and drops a still-high trigger
               if (match_s && (period_r == (acq_len_r - 4'd1))) begin
                  state_nxt_s = DONE_IP2_DC;
                  trig_nxt_s  = 1'b0;
               end else if (match_s) begin
                  period_nxt_s = period_r + 4'd1;
               end else begin
                  period_nxt_s = period_r;
               end
            end
            DONE_IP2_DC: begin
               state_nxt_s = IDLE_IP2_DC;
            end
            default: begin
               state_nxt_s = IDLE_IP2_DC;
               trig_nxt_s  = 1'b0;
            end
         endcase
      end
   end

   // State, period counter and DUT-facing pulse registers
   always_ff @(posedge clk or negedge reset_not) begin
      if (!reset_not) begin
         state_r     <= IDLE_IP2_DC;
         period_r    <= 4'd0;
         reset_not_r <= 1'b1;
         trig_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         period_r    <= period_nxt_s;
         reset_not_r <= reset_not_nxt_s;
         trig_r      <= trig_nxt_s;
      end
   end

   // Test configuration latch, sample counter and status flags
   always_ff @(posedge clk or negedge reset_not) begin
      if (!reset_not) begin
         acq_len_r    <= 4'd1;
         mode_r       <= CAPTURE_MODE_FIRST;
         sample_cnt_r <= 8'd0;
         done_r       <= 1'b0;
         overflow_r   <= 1'b0;
      end else if (start_s) begin
         acq_len_r    <= periods_min1(acq_periods);
         mode_r       <= capture_mode;
         sample_cnt_r <= 8'd0;
         done_r       <= 1'b0;
         overflow_r   <= 1'b0;
      end else begin
         if (active_s && (sample_cnt_r != 8'hFF)) begin
            sample_cnt_r <= sample_cnt_r + 8'd1;
         end else begin
            sample_cnt_r <= sample_cnt_r;
         end
         if (active_s && (mode_r == CAPTURE_MODE_FIRST) && (sample_cnt_r >= DEPTH_CNT)) begin
            overflow_r <= 1'b1;
         end else begin
            overflow_r <= overflow_r;
         end
         if (enter_done_s) begin
            done_r <= 1'b1;
         end else begin
            done_r <= done_r;
         end
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      ip2_capture_shreg #(.DEPTH(DEPTH)) u_shreg (
         .clk       (clk),
         .reset_not (reset_not),
         .clr       (start_s),
         .shift_en  (shift_en_s),
         .din       (dnn_in[c]),
         .dout      (o_dnn_capture[c*DEPTH +: DEPTH])
      );
   end

   assign state               = state_r;
   assign o_reset_not         = reset_not_r;
   assign o_vin_test_trig_out = trig_r;
   assign o_status_done       = done_r;
   assign o_status_overflow   = overflow_r;
   assign o_sample_cnt        = sample_cnt_r;

endmodule
